// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: write-side front end of async_fifo, wr_clk domain only.
// Packs an IN_WIDTH-bit valid/ready beat stream into DATA_WIDTH-bit words,
// LSB-first, and hands each word to async_fifo through a one-word holding
// register that honours the registered fifo_full flag. s_last closes a
// partial word early; unused upper slots are written as zero.
//
// Parameters
//   IN_WIDTH    input beat width (DATA_WIDTH must be a multiple of it)
//   DATA_WIDTH  FIFO word width; RATIO = DATA_WIDTH/IN_WIDTH must be >= 2
//   CNT_WIDTH   width of the words_written counter
//
// Ports
//   wr_clk, wr_rst_n   write clock, asynchronous active-low reset
//   s_valid/s_ready    input handshake; beat accepted when both high
//   s_data, s_last     beat payload and end-of-packet marker
//   fifo_full          async_fifo full flag (registered, wr_clk domain)
//   fifo_wr_en         write strobe to async_fifo (combinational)
//   fifo_wr_data       packed word to async_fifo
//   busy               partial word in progress or word pending
//   words_written      number of words written, wraps modulo 2^CNT_WIDTH
module fifo_wr_packer #(
  parameter int unsigned IN_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_written
);

  localparam int unsigned RATIO  = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned SLOT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int unsigned ACC_W  = DATA_WIDTH - IN_WIDTH;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

  // Registered state and its next-state values
  logic [SLOT_W-1:0]     cnt,       cnt_n;
  logic [ACC_W-1:0]      acc,       acc_n;
  logic [DATA_WIDTH-1:0] out_data,  out_data_n;
  logic                  out_valid, out_valid_n;
  logic [CNT_WIDTH-1:0]  words,     words_n;

  logic                  accept_c;
  logic                  complete_c;
  logic [DATA_WIDTH-1:0] word_c;

  // Handshake and FIFO strobe are combinational views of the holding register
  assign fifo_wr_en   = out_valid & ~fifo_full;
  assign s_ready      = wr_rst_n & (~out_valid | ~fifo_full);
  assign fifo_wr_data = out_data;
  assign busy         = (cnt != '0) | out_valid;
  assign words_written = words;

  assign accept_c   = s_valid & s_ready;
  assign complete_c = accept_c & (s_last | (cnt == LAST_SLOT));

  // Word closed by the current beat: stored slots plus this beat at slot cnt.
  // acc is cleared after every word, so slots above cnt are already zero.
  always_comb begin
    word_c            = '0;
    word_c[ACC_W-1:0] = acc;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt == SLOT_W'(k)) begin
        word_c[k*IN_WIDTH +: IN_WIDTH] = s_data;
      end
    end
  end

  // Next-state logic for the packer and the holding register
  always_comb begin
    cnt_n       = cnt;
    acc_n       = acc;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    words_n     = words + CNT_WIDTH'(fifo_wr_en);

    if (complete_c) begin
      // Reload may coincide with a write of the previous word; out_valid stays set
      cnt_n       = '0;
      acc_n       = '0;
      out_data_n  = word_c;
      out_valid_n = 1'b1;
    end else begin
      if (accept_c) begin
        cnt_n = cnt + SLOT_W'(1);
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (cnt == SLOT_W'(k)) begin
            acc_n[k*IN_WIDTH +: IN_WIDTH] = s_data;
          end
        end
      end
      if (fifo_wr_en) begin
        out_valid_n = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      words     <= '0;
    end else begin
      cnt       <= cnt_n;
      acc       <= acc_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      words     <= words_n;
    end
  end

endmodule
